// File: rtl/apb_acc_pkg.sv
// rtl/apb_acc_pkg.sv - register map, APB FSM encoding and timeout counter width
package apb_acc_pkg;

    localparam int DATA_BASE  = 'h000;
    localparam int STATUS_OFS = 'h100;
    localparam int IRQEN_OFS  = 'h104;
    localparam int TMO_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_acc_chan.sv
// rtl/apb_acc_chan.sv - one accelerator channel: operand, start pulse, busy, result, sticky done
module apb_acc_chan #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wdata,
    input  logic          clr,
    input  logic [DW-1:0] acc_din,
    input  logic          acc_done,
    output logic [DW-1:0] dout,
    output logic          start,
    output logic          busy,
    output logic [DW-1:0] result,
    output logic          done
);

    logic [DW-1:0] dout_q, dout_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] result_q, result_d;
    logic          done_q, done_d;

    // An accepted write keeps busy set even if a done arrives in the same cycle;
    // a done pulse always wins over a W1C clear of the flag.
    always_comb begin
        dout_d   = wr_en ? wdata : dout_q;
        start_d  = wr_en;
        busy_d   = wr_en ? 1'b1 : (acc_done ? 1'b0 : busy_q);
        result_d = acc_done ? acc_din : result_q;
        done_d   = acc_done ? 1'b1 : (clr ? 1'b0 : done_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign dout   = dout_q;
    assign start  = start_q;
    assign busy   = busy_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: rtl/apb_acc_regbank.sv
// rtl/apb_acc_regbank.sv - APB register bank fronting NCH accelerator channels
module apb_acc_regbank
    import apb_acc_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = 12,
    parameter int AW  = 12,
    parameter int TMO = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [AW-1:0]     PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NCH*DW-1:0] acc_dout,
    output logic [NCH-1:0]    acc_start,
    input  logic [NCH*DW-1:0] acc_din,
    input  logic [NCH-1:0]    acc_done,
    output logic              irq
);

    apb_state_e       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   irq_en_q, irq_en_d;
    logic             irq_q, irq_d;

    logic [NCH-1:0]    busy_v, done_v, wr_en_v, clr_v, sel_oh;
    logic [NCH*DW-1:0] res_flat;
    logic [AW-1:0]     addr_w, off;
    logic [3:0]        idx;
    logic              is_data, is_status, is_irqen, busy_sel, acc_ph;
    logic [DW-1:0]     res_sel;
    logic              unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        addr_w    = {PADDR[AW-1:2], 2'b00};
        off       = addr_w - AW'(DATA_BASE);
        is_data   = off < AW'(4 * NCH);
        is_status = addr_w == AW'(STATUS_OFS);
        is_irqen  = addr_w == AW'(IRQEN_OFS);
        idx       = off[5:2];
        acc_ph    = PSEL & PENABLE;
        sel_oh    = '0;
        res_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_oh[i] = is_data && (idx == 4'(i));
            if (sel_oh[i]) res_sel = res_flat[i*DW +: DW];
        end
        busy_sel = |(busy_v & sel_oh);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        irq_en_d = irq_en_q;
        wr_en_v  = '0;
        clr_v    = '0;
        PREADY   = 1'b1;
        PSLVERR  = 1'b0;
        PRDATA   = '0;
        case (state_q)
            ST_IDLE: if (PSEL && !PENABLE) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (!acc_ph) begin
                    state_d = ST_IDLE;
                end else if (!PWRITE && busy_sel) begin
                    // The access cycle itself is the first wait cycle
                    PREADY  = 1'b0;
                    cnt_d   = TMO_W'(1);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                    if (PWRITE) begin
                        if (is_data) begin
                            if (busy_sel) PSLVERR = 1'b1;
                            else          wr_en_v = sel_oh;
                        end else if (is_status) clr_v    = PWDATA[NCH-1:0];
                        else if (is_irqen)      irq_en_d = PWDATA[NCH-1:0];
                        else                    PSLVERR  = 1'b1;
                    end else begin
                        if (is_data)        PRDATA  = 32'(res_sel);
                        else if (is_status) PRDATA  = {16'(busy_v), 16'(done_v)};
                        else if (is_irqen)  PRDATA  = 32'(irq_en_q);
                        else                PSLVERR = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!acc_ph) begin
                    state_d = ST_IDLE;
                end else if (!busy_sel) begin
                    PRDATA  = 32'(res_sel);
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_W'(TMO)) begin
                    PSLVERR = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    PREADY = 1'b0;
                    cnt_d  = cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = |(done_v & irq_en_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        apb_acc_chan #(.DW(DW)) u_chan (
            .clk      (PCLK),
            .rst_n    (PRESETn),
            .wr_en    (wr_en_v[g]),
            .wdata    (PWDATA[DW-1:0]),
            .clr      (clr_v[g]),
            .acc_din  (acc_din[g*DW +: DW]),
            .acc_done (acc_done[g]),
            .dout     (acc_dout[g*DW +: DW]),
            .start    (acc_start[g]),
            .busy     (busy_v[g]),
            .result   (res_flat[g*DW +: DW]),
            .done     (done_v[g])
        );
    end

endmodule

// File: tb/tb_apb_acc_regbank.sv
// tb/tb_apb_acc_regbank.sv - directed self-checking bench for apb_acc_regbank
module tb_apb_acc_regbank;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int AW  = 12;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [31:0]       PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic [NCH*DW-1:0] acc_dout, acc_din;
    logic [NCH-1:0]    acc_start, acc_done;
    logic              irq;

    int tests = 0;
    int fails = 0;

    apb_acc_regbank #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(255)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .acc_dout(acc_dout),
        .acc_start(acc_start), .acc_din(acc_din), .acc_done(acc_done), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        int n;
        @(posedge PCLK);
        #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        for (n = 0; n < 400; n++) begin
            @(negedge PCLK);
            if (PREADY) break;
        end
        if (n == 400) check("bus_hang", 32'(PREADY), 32'd1);
        waits = n;
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; acc_din = {12'h456, 12'h123}; acc_done = '0;
        @(negedge PCLK);
        check("rst_pready", 32'(PREADY), 32'd1);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_dout", 32'(acc_dout), 32'd0);
        check("rst_start", 32'(acc_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // operand write, upper PWDATA bits ignored
        apb_xfer(1'b1, 12'h000, 32'hFFFF_FABC, rd, er, wt);
        check("wr0_err", 32'(er), 32'd0);
        @(negedge PCLK);
        check("wr0_start", 32'(acc_start), 32'h1);
        check("wr0_dout", 32'(acc_dout[11:0]), 32'hABC);
        @(negedge PCLK);
        check("wr0_start_off", 32'(acc_start), 32'h0);
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, wt);
        check("status_busy0", rd, 32'h0001_0000);

        // wait-stated read finishing on done 5 cycles in
        fork
            apb_xfer(1'b0, 12'h000, 32'h0, rd, er, wt);
            begin
                @(posedge PCLK);
                repeat (5) @(posedge PCLK);
                #1 acc_done = 2'b01;
                @(posedge PCLK);
                #1 acc_done = 2'b00;
            end
        join
        check("wait_rd_data", rd, 32'h123);
        check("wait_rd_waits", 32'(wt), 32'd5);
        check("wait_rd_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, wt);
        check("status_done0", rd, 32'h0000_0001);

        // write to busy channel is rejected
        apb_xfer(1'b1, 12'h004, 32'h001, rd, er, wt);
        check("wr1_err", 32'(er), 32'd0);
        apb_xfer(1'b1, 12'h004, 32'h777, rd, er, wt);
        check("wr1_busy_err", 32'(er), 32'd1);
        check("wr1_busy_dout", 32'(acc_dout[23:12]), 32'h001);
        @(negedge PCLK);
        check("wr1_busy_start", 32'(acc_start), 32'h0);

        // unmapped address
        apb_xfer(1'b1, 12'h200, 32'h5, rd, er, wt);
        check("bad_wr_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 12'h200, 32'h0, rd, er, wt);
        check("bad_rd_err", 32'(er), 32'd1);
        check("bad_rd_data", rd, 32'h0);

        // busy read that never completes
        apb_xfer(1'b0, 12'h004, 32'h0, rd, er, wt);
        check("tmo_waits", 32'(wt), 32'd255);
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_data", rd, 32'h0);

        // clear done[0], enable irqs, then done[1]
        apb_xfer(1'b1, 12'h100, 32'h1, rd, er, wt);
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, wt);
        check("status_w1c", rd, 32'h0002_0000);
        apb_xfer(1'b1, 12'h104, 32'h3, rd, er, wt);
        apb_xfer(1'b0, 12'h104, 32'h0, rd, er, wt);
        check("irqen_rd", rd, 32'h3);
        check("irq_off", 32'(irq), 32'd0);
        #1 acc_done = 2'b10;
        @(posedge PCLK);
        #1 acc_done = 2'b00;
        @(negedge PCLK);
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge PCLK);
        check("irq_on", 32'(irq), 32'd1);

        // W1C of done[1] coinciding with a fresh done[1]
        acc_din = {12'h9A5, 12'h123};
        fork
            apb_xfer(1'b1, 12'h100, 32'h2, rd, er, wt);
            begin
                @(posedge PCLK);
                @(posedge PCLK);
                #1 acc_done = 2'b10;
                @(posedge PCLK);
                #1 acc_done = 2'b00;
            end
        join
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, wt);
        check("set_wins", rd, 32'h0000_0002);
        apb_xfer(1'b0, 12'h004, 32'h0, rd, er, wt);
        check("result1", rd, 32'h9A5);
        check("irq_held", 32'(irq), 32'd1);

        // reset in the middle of a wait-stated read
        apb_xfer(1'b1, 12'h000, 32'h055, rd, er, wt);
        @(posedge PCLK);
        #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h000;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("mid_wait_pready", 32'(PREADY), 32'd0);
        #1 PRESETn = 1'b0;
        #1;
        check("rstw_pready", 32'(PREADY), 32'd1);
        check("rstw_irq", 32'(irq), 32'd0);
        check("rstw_dout", 32'(acc_dout), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        apb_xfer(1'b0, 12'h100, 32'h0, rd, er, wt);
        check("rstw_status", rd, 32'h0);
        apb_xfer(1'b0, 12'h104, 32'h0, rd, er, wt);
        check("rstw_irqen", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
